// File: rtl/cache_bus_sequencer.sv
// Bus-side sequencer feeding the sector coherence FSM; classes/req_ack/snoops/AllInvDone registered (1 cycle), READ_DONE decoded from FILL count.
// Requests accepted only in IDLE (requester holds cpu_req); optional invalidate timeout under `CACHE_SEQ_INV_TIMEOUT_EN`.
module cache_bus_sequencer #(
  parameter int READ_LAT    = 3,
  parameter int NUM_PEERS   = 1,
  parameter int INV_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_wr,
  input  logic                 cpu_hit,
  input  logic                 shared_in,
  input  logic                 snoop_valid,
  input  logic                 snoop_wr,
  input  logic                 snoop_hit,
  input  logic                 Cache_Sector_Fill,
  input  logic                 Invalidate,
  input  logic                 AdrRetry,
  input  logic [NUM_PEERS-1:0] inv_ack,
  input  logic                 wb_ack,
  input  logic                 mem_abort,
  output logic                 req_ack,
  output logic                 RMS,
  output logic                 RME,
  output logic                 WM,
  output logic                 WH,
  output logic                 SHR,
  output logic                 SHW,
  output logic                 READ_DONE,
  output logic                 send_abort,
  output logic                 write_back_done,
  output logic                 AllInvDone,
  output logic                 busy,
  output logic                 inv_timeout_err
);

  if (READ_LAT < 1 || READ_LAT > 15 || NUM_PEERS < 1 || INV_TIMEOUT < 1) begin : g_bad_param
    $error("cache_bus_sequencer: illegal parameter value");
  end

  localparam int CW = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FILL, S_INV_WAIT} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [NUM_PEERS-1:0] r_mask;
  logic [3:0]           r_cls;
  logic                 r_req_ack;
  logic                 r_send_abort;
  logic                 r_all_inv;
  logic                 r_shr;
  logic                 r_shw;
  logic                 r_wb_pending;
  logic                 r_wb_done;
  logic                 w_mask_full;
  logic                 w_tmo;

  // Includes this cycle's acks so completion does not wait an extra cycle.
  assign w_mask_full = &(r_mask | inv_ack);

`ifdef CACHE_SEQ_INV_TIMEOUT_EN
  localparam int TW = $clog2(INV_TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  assign w_tmo = (r_state == S_INV_WAIT) && (r_tcnt == TW'(INV_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != S_INV_WAIT) r_tcnt <= '0;
      else if (!w_tmo)           r_tcnt <= r_tcnt + 1'b1;
      if (w_tmo && !w_mask_full) r_err <= 1'b1;
    end
  end
  assign inv_timeout_err = r_err;
`else
  assign w_tmo           = 1'b0;
  assign inv_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_cls        <= '0;
      r_req_ack    <= 1'b0;
      r_send_abort <= 1'b0;
      r_all_inv    <= 1'b0;
    end else begin
      r_req_ack    <= 1'b0;
      r_send_abort <= 1'b0;
      r_all_inv    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_req_ack <= 1'b1;
            r_cls     <= {!cpu_hit && !cpu_wr && shared_in,
                          !cpu_hit && !cpu_wr && !shared_in,
                          !cpu_hit && cpu_wr,
                          cpu_hit && cpu_wr};
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (Cache_Sector_Fill) begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_FILL;
          end else if (Invalidate) begin
            r_mask  <= '0;
            r_state <= S_INV_WAIT;
          end else begin
            r_cls   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          // Abort beats the final count; READ_DONE is suppressed combinationally.
          if (mem_abort) begin
            r_send_abort <= 1'b1;
            r_cls        <= '0;
            r_state      <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_INV_WAIT: begin
          r_mask <= r_mask | inv_ack;
          if (w_mask_full || w_tmo) begin
            r_all_inv <= 1'b1;
            r_cls     <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shr        <= 1'b0;
      r_shw        <= 1'b0;
      r_wb_pending <= 1'b0;
      r_wb_done    <= 1'b0;
    end else begin
      r_shr     <= snoop_valid && snoop_hit && !snoop_wr;
      r_shw     <= snoop_valid && snoop_hit && snoop_wr;
      r_wb_done <= 1'b0;
      // A fresh retry in the same cycle as the ack re-arms instead of completing.
      if (AdrRetry) begin
        r_wb_pending <= 1'b1;
      end else if (wb_ack && r_wb_pending) begin
        r_wb_pending <= 1'b0;
        r_wb_done    <= 1'b1;
      end
    end
  end

  assign req_ack         = r_req_ack;
  assign {RMS, RME, WM, WH} = r_cls;
  assign SHR             = r_shr;
  assign SHW             = r_shw;
  assign READ_DONE       = (r_state == S_FILL) && (r_cnt == '0) && !mem_abort;
  assign send_abort      = r_send_abort;
  assign write_back_done = r_wb_done;
  assign AllInvDone      = r_all_inv;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_bus_sequencer.sv
// Bench for cache_bus_sequencer: per-cycle vector table through an expected-value queue, plus hand-written corner sequences.
module tb_cache_bus_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       cpu_req, cpu_wr, cpu_hit, shared_in;
  logic       snoop_valid, snoop_wr, snoop_hit;
  logic       Cache_Sector_Fill, Invalidate, AdrRetry;
  logic       mem_abort, wb_ack;
  logic [1:0] inv_ack;

  // {req_ack, RMS, RME, WM, WH, SHR, SHW, READ_DONE, send_abort, write_back_done, AllInvDone, busy, inv_timeout_err}
  wire [12:0] m_o;
  wire [12:0] l1_o;

  cache_bus_sequencer #(.READ_LAT(3), .NUM_PEERS(2), .INV_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_hit(cpu_hit), .shared_in(shared_in),
    .snoop_valid(snoop_valid), .snoop_wr(snoop_wr), .snoop_hit(snoop_hit),
    .Cache_Sector_Fill(Cache_Sector_Fill), .Invalidate(Invalidate), .AdrRetry(AdrRetry),
    .inv_ack(inv_ack), .wb_ack(wb_ack), .mem_abort(mem_abort),
    .req_ack(m_o[12]), .RMS(m_o[11]), .RME(m_o[10]), .WM(m_o[9]), .WH(m_o[8]),
    .SHR(m_o[7]), .SHW(m_o[6]), .READ_DONE(m_o[5]), .send_abort(m_o[4]),
    .write_back_done(m_o[3]), .AllInvDone(m_o[2]), .busy(m_o[1]), .inv_timeout_err(m_o[0])
  );

  cache_bus_sequencer #(.READ_LAT(1), .NUM_PEERS(2), .INV_TIMEOUT(16)) u_l1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_hit(cpu_hit), .shared_in(shared_in),
    .snoop_valid(snoop_valid), .snoop_wr(snoop_wr), .snoop_hit(snoop_hit),
    .Cache_Sector_Fill(Cache_Sector_Fill), .Invalidate(Invalidate), .AdrRetry(AdrRetry),
    .inv_ack(inv_ack), .wb_ack(wb_ack), .mem_abort(mem_abort),
    .req_ack(l1_o[12]), .RMS(l1_o[11]), .RME(l1_o[10]), .WM(l1_o[9]), .WH(l1_o[8]),
    .SHR(l1_o[7]), .SHW(l1_o[6]), .READ_DONE(l1_o[5]), .send_abort(l1_o[4]),
    .write_back_done(l1_o[3]), .AllInvDone(l1_o[2]), .busy(l1_o[1]), .inv_timeout_err(l1_o[0])
  );

  typedef struct {
    string       nm;
    logic [13:0] vin;   // {req,wr,hit,shared, snv,snwr,snhit, fill,inv,retry, abort,wback, inv_ack[1:0]}
    logic [12:0] vexp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  string       nm_q[$];
  logic [1:0]  l1_snap;
  logic        tmo = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  // Drives one cycle of inputs just after posedge, checks outputs at the following negedge.
  task automatic step(input string nm, input logic [13:0] vin, input logic [12:0] vexp);
    string       n;
    logic [12:0] e;
    {cpu_req, cpu_wr, cpu_hit, shared_in, snoop_valid, snoop_wr, snoop_hit,
     Cache_Sector_Fill, Invalidate, AdrRetry, mem_abort, wb_ack, inv_ack} = vin;
    exp_q.push_back(vexp | {12'b0, tmo});
    nm_q.push_back(nm);
    @(negedge clk);
    l1_snap = {l1_o[5], l1_o[1]};
    n = nm_q.pop_front();
    e = exp_q.pop_front();
    chk(n, m_o, e);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic [13:0] i, input logic [12:0] e);
    vec_t v;
    v.nm = n; v.vin = i; v.vexp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    // read miss, not shared: RME for CHECK + 3 FILL + CHECK, READ_DONE in 3rd FILL cycle
    add("rme_req",  14'b1000_000_000_00_00, 13'b0_0000_00_0000_00);
    add("rme_chk",  14'b0000_000_100_00_00, 13'b1_0100_00_0000_10);
    add("rme_f2",   14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    add("rme_f1",   14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    add("rme_f0",   14'b0000_000_000_00_00, 13'b0_0100_00_1000_10);
    add("rme_chk2", 14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    add("rme_idle", 14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    // read hit: no class; request held through CHECK is not re-accepted
    add("hr_req",   14'b1010_000_000_00_00, 13'b0_0000_00_0000_00);
    add("hr_chk",   14'b1010_000_000_00_00, 13'b1_0000_00_0000_10);
    add("hr_ign",   14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    // write miss: fill, then invalidate with 2 peers, acks at +2 (+ repeat at +3) and +5
    add("wm_req",   14'b1100_000_000_00_00, 13'b0_0000_00_0000_00);
    add("wm_chk",   14'b0000_000_100_00_00, 13'b1_0010_00_0000_10);
    add("wm_f2",    14'b0000_000_000_00_00, 13'b0_0010_00_0000_10);
    add("wm_f1",    14'b0000_000_000_00_00, 13'b0_0010_00_0000_10);
    add("wm_f0",    14'b0000_000_000_00_00, 13'b0_0010_00_1000_10);
    add("wm_chk2",  14'b0000_000_010_00_00, 13'b0_0010_00_0000_10);
    add("wm_inv1",  14'b0000_000_000_00_00, 13'b0_0010_00_0000_10);
    add("wm_inv2",  14'b0000_000_000_00_01, 13'b0_0010_00_0000_10);
    add("wm_inv3",  14'b0000_000_000_00_01, 13'b0_0010_00_0000_10);
    add("wm_inv4",  14'b0000_000_000_00_00, 13'b0_0010_00_0000_10);
    add("wm_inv5",  14'b0000_000_000_00_10, 13'b0_0010_00_0000_10);
    add("wm_done",  14'b0000_000_000_00_00, 13'b0_0000_00_0001_00);
    add("wm_idle",  14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    // shared read miss aborted on the cycle the count hits 0
    add("ab_req",   14'b1001_000_000_00_00, 13'b0_0000_00_0000_00);
    add("ab_chk",   14'b0000_000_100_00_00, 13'b1_1000_00_0000_10);
    add("ab_f2",    14'b0000_000_000_00_00, 13'b0_1000_00_0000_10);
    add("ab_f1",    14'b0000_000_000_00_00, 13'b0_1000_00_0000_10);
    add("ab_f0",    14'b0000_000_000_10_00, 13'b0_1000_00_0000_10);
    add("ab_out",   14'b0000_000_000_00_00, 13'b0_0000_00_0100_00);
    add("ab_idle",  14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    // write-back tracker
    add("wb_retry", 14'b0000_000_001_00_00, 13'b0_0000_00_0000_00);
    add("wb_w1",    14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    add("wb_w2",    14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    add("wb_w3",    14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);
    add("wb_ack",   14'b0000_000_000_01_00, 13'b0_0000_00_0000_00);
    add("wb_done",  14'b0000_000_000_01_00, 13'b0_0000_00_0010_00);
    add("wb_stray", 14'b0000_000_001_01_00, 13'b0_0000_00_0000_00);
    add("wb_same",  14'b0000_000_000_01_00, 13'b0_0000_00_0000_00);
    add("wb_late",  14'b0000_000_000_00_00, 13'b0_0000_00_0010_00);
    // snoop write hit alongside a write-hit request, then snoop read hit, then non-valid hit
    add("sn_req",   14'b1110_111_000_00_00, 13'b0_0000_00_0000_00);
    add("sn_chk",   14'b0000_101_000_00_00, 13'b1_0001_01_0000_10);
    add("sn_shr",   14'b0000_001_000_00_00, 13'b0_0000_10_0000_00);
    add("sn_none",  14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);

    reset_n = 1'b0;
    {cpu_req, cpu_wr, cpu_hit, shared_in, snoop_valid, snoop_wr, snoop_hit,
     Cache_Sector_Fill, Invalidate, AdrRetry, mem_abort, wb_ack, inv_ack} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", m_o, 13'b0);
    chk("reset_l1", l1_o, 13'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].nm, vecs[i].vin, vecs[i].vexp);

    // READ_LAT=1 instance: READ_DONE in the cycle right after the fill is sampled
    step("l1_req", 14'b1000_000_000_00_00, 13'b0_0000_00_0000_00);
    step("l1_chk", 14'b0000_000_100_00_00, 13'b1_0100_00_0000_10);
    chk("l1_in_check", {11'b0, l1_snap}, 13'b01);
    step("l1_f2",  14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    chk("l1_read_done", {11'b0, l1_snap}, 13'b11);
    step("l1_f1",  14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    chk("l1_back_check", {11'b0, l1_snap}, 13'b01);
    step("l1_f0",  14'b0000_000_000_00_00, 13'b0_0100_00_1000_10);
    chk("l1_idle", {11'b0, l1_snap}, 13'b00);
    step("l1_chk3", 14'b0000_000_000_00_00, 13'b0_0100_00_0000_10);
    step("l1_end",  14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);

`ifdef CACHE_SEQ_INV_TIMEOUT_EN
    step("to_req", 14'b1000_000_000_00_00, 13'b0_0000_00_0000_00);
    step("to_chk", 14'b0000_000_010_00_00, 13'b1_0100_00_0000_10);
    for (int k = 0; k < 16; k++) step("to_wait", 14'b0, 13'b0_0100_00_0000_10);
    step("to_fire", 14'b0, 13'b0_0000_00_0001_01);
    tmo = 1'b1;
    step("to_held", 14'b0, 13'b0_0000_00_0000_00);
`endif

    // asynchronous reset in the middle of INV_WAIT with a registered snoop pulse pending
    step("rs_req",  14'b1000_000_000_00_00, 13'b0_0000_00_0000_00);
    step("rs_chk",  14'b0000_000_010_00_00, 13'b1_0100_00_0000_10);
    step("rs_wait", 14'b0000_101_000_00_01, 13'b0_0100_00_0000_10);
    {cpu_req, cpu_wr, cpu_hit, shared_in, snoop_valid, snoop_wr, snoop_hit,
     Cache_Sector_Fill, Invalidate, AdrRetry, mem_abort, wb_ack, inv_ack} = '0;
    #2;
    chk("rs_pre", m_o, 13'b0_0100_10_0000_10 | {12'b0, tmo});
    reset_n = 1'b0;
    #1;
    chk("rs_async", m_o, 13'b0);
    tmo = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rs_held", m_o, 13'b0);
    @(posedge clk);
    #1;
    step("rs_new",     14'b1100_000_000_00_00, 13'b0_0000_00_0000_00);
    step("rs_new_chk", 14'b0000_000_000_00_00, 13'b1_0010_00_0000_10);
    step("rs_new_end", 14'b0000_000_000_00_00, 13'b0_0000_00_0000_00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_bus_sequencer.md
# cache_bus_sequencer

Bus-side sequencer that sits directly upstream of the per-sector cache coherence FSM and produces all of its request, snoop and completion inputs. It classifies processor requests into read-miss-shared, read-miss-exclusive, write-miss and write-hit levels, and registers bus snoop hits. It also times the memory sector read, collects peer invalidate acknowledgements and tracks write-back completion. It consumes the coherence FSM's Cache_Sector_Fill, Invalidate and AdrRetry outputs to close each transaction.

## Interface
- READ_LAT, 3: cycles from sampled Cache_Sector_Fill to READ_DONE; legal range 1..15.
- NUM_PEERS, 1: number of peer caches that must acknowledge an invalidate.
- INV_TIMEOUT, 16: invalidate-wait cycle limit; used only with the Configuration macro.
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  processor request valid; accepted only while busy=0.
- cpu_wr  in  1  request is a write.
- cpu_hit  in  1  tag hit for the request.
- shared_in  in  1  bus shared line; another cache holds the sector.
- snoop_valid  in  1  bus transaction from another master this cycle.
- snoop_wr  in  1  snooped transaction is a write.
- snoop_hit  in  1  snooped address hits the local sector.
- Cache_Sector_Fill  in  1  from coherence FSM.
- Invalidate  in  1  from coherence FSM.
- AdrRetry  in  1  from coherence FSM.
- inv_ack  in  NUM_PEERS  per-peer invalidate acknowledge pulses.
- wb_ack  in  1  memory reports write-back complete.
- mem_abort  in  1  a peer aborts the in-progress sector read.
- req_ack  out  1  one-cycle pulse on request acceptance.
- RMS, RME, WM, WH  out  1 each  request class levels.
- SHR, SHW  out  1 each  registered snoop-hit pulses.
- READ_DONE, send_abort, write_back_done, AllInvDone  out  1 each  one-cycle pulses.
- busy  out  1  state is not IDLE.
- inv_timeout_err  out  1  sticky invalidate timeout flag.

## Operation
- Reset: state IDLE, all outputs 0, counters and ack mask cleared.
- **IDLE**
  - On cpu_req=1, latch the request class and pulse req_ack:
    - miss read → RMS if shared_in=1, otherwise RME.
    - miss write → WM.
    - hit write → WH.
    - hit read → no class.
  - Go to CHECK.
  - cpu_req while busy=1 is ignored; the requester holds it.
- **CHECK** (exactly one cycle)
  - Cache_Sector_Fill=1 → FILL, down-counter loaded with READ_LAT-1.
  - Else Invalidate=1 → INV_WAIT, ack mask cleared.
  - Else clear class → IDLE.
- **FILL**
  - Counter decrements each cycle.
  - At 0: pulse READ_DONE → CHECK, so that a WM fill's Invalidate is picked up.
  - mem_abort in FILL: pulse send_abort, clear class → IDLE, no READ_DONE. mem_abort in the same cycle the counter reaches 0: abort wins.
- **INV_WAIT**
  - Ack mask |= inv_ack.
  - When the mask is all ones (including the ack arriving that cycle): pulse AllInvDone, clear class → IDLE.
- Class levels are held constant from acceptance until return to IDLE.
- Snoop path runs independently of state:
  - SHR = snoop_valid & snoop_hit & !snoop_wr, registered.
  - SHW = snoop_valid & snoop_hit & snoop_wr, registered.
  - Both may coincide with any class level; the coherence FSM resolves priority.
- Write-back tracker runs independently:
  - AdrRetry sets wb_pending.
  - wb_ack while wb_pending pulses write_back_done and clears wb_pending.
  - AdrRetry and wb_ack in the same cycle: pending is set, no pulse.
  - wb_ack with no pending is ignored.
- reset_n low in any state aborts immediately to reset values; no pulse is emitted.

## Timing
- req_ack and the class level both rise in the cycle after cpu_req is sampled.
- SHR/SHW: one-cycle latency from the snoop inputs.
- READ_DONE is high in the READ_LAT-th cycle after the edge that sampled Cache_Sector_Fill. READ_LAT=1 gives the next cycle.
- AllInvDone: one cycle after the edge that completes the ack mask.
- write_back_done: one cycle after wb_ack is sampled.
- Minimum transaction length is 2 cycles (accept + CHECK). The next request can be accepted in the first IDLE cycle.
- Counters use $clog2(max+1) bits with no wrap; FILL cannot underflow because it exits at 0.

## Configuration
- CACHE_SEQ_INV_TIMEOUT_EN defined:
  - A cycle counter starts on INV_WAIT entry.
  - If INV_TIMEOUT cycles elapse without all acks: pulse AllInvDone, set inv_timeout_err (sticky until reset), → IDLE.
  - All acks in the same cycle as timeout: normal completion, no error.
- Undefined: INV_WAIT waits indefinitely; inv_timeout_err is tied 0 and no timeout counter is built.

## Test plan
- Read miss with shared_in=0, Cache_Sector_Fill seen in CHECK, READ_LAT=3 → RME high 5 cycles total, READ_DONE pulse exactly 3 cycles after CHECK, busy drops next cycle.
- Write miss, fill, then Invalidate in the post-READ_DONE CHECK, NUM_PEERS=2, acks on cycles +2 and +5 → AllInvDone pulse at +6, WM held throughout.
- mem_abort on the same cycle as the FILL counter reaching 0 → send_abort pulse, no READ_DONE, class cleared, busy=0.
- AdrRetry then wb_ack 4 cycles later; separately AdrRetry and wb_ack in the same cycle → first case gives one write_back_done pulse; second case none until the next wb_ack.
- snoop_valid=1, snoop_hit=1, snoop_wr=1 concurrent with cpu_req write-hit → SHW and WH both high the next cycle; reset_n pulsed low mid-INV_WAIT → all outputs 0 immediately.
- With CACHE_SEQ_INV_TIMEOUT_EN defined, INV_TIMEOUT=16, no acks → AllInvDone at cycle 16 after entry, inv_timeout_err=1 and held until reset.
